// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream master.
// No logic; imported by the skid buffer and the reader top.
// Backpressure: not applicable.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int SKID_DEPTH = 2;

  // Modulo-(last+1) increment used for the burst position counters.
  function automatic logic [15:0] wrap_inc(input logic [15:0] idx, input logic [15:0] last);
    return (idx == last) ? 16'd0 : idx + 16'd1;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register FIFO carrying {last,data} between the FIFO read port and the stream.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: the caller must not push into a full buffer unless it also pops that cycle.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic [1:0]   occ_o
);

  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop_i && (occ_q != 2'd0);
  assign push_ok = push_i && ((occ_q != FULL) || pop_ok);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = push_dat_i;
        else               ent1_d = push_dat_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Head leaves while a new word arrives; occupancy is unchanged.
        if (occ_q == FULL) begin
          ent0_d = ent1_q;
          ent1_d = push_dat_i;
        end else begin
          ent0_d = push_dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_dat_o = ent0_q;
  assign occ_o      = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from a FIFO with 1-cycle read latency and streams them with burst framing.
// Latency: first beat 2 cycles after the first read; 1 beat/cycle sustained.
// Backpressure: m_ready low holds the head; reads stop once buffered+in-flight reaches 2.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic [CNT_W-1:0] beat_count
);

  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  rd_state_t        state_q, state_d;
  logic             inflight_q;
  logic [15:0]      cap_idx_q, cap_idx_d;
  logic [15:0]      burst_idx_q, burst_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [1:0]       occ;
  logic [WIDTH:0]   head;
  logic [WIDTH:0]   cap_word;
  logic             pop;
  logic [2:0]       pending;

  // Words owed to the stream after this cycle: buffered + arriving - leaving.
  assign pop      = m_valid & m_ready;
  assign pending  = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

  assign fifo_rd_en = (state_q == RUN) & enable & ~fifo_empty & (pending < 3'(SKID_DEPTH));

  // The last flag is fixed when a word is captured, so it travels with the data.
  assign cap_word = {(cap_idx_q == LAST_IDX), fifo_data};

  fifo_skid_buf #(.W(WIDTH + 1)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push_i     (inflight_q),
    .push_dat_i (cap_word),
    .pop_i      (pop),
    .head_dat_o (head),
    .occ_o      (occ)
  );

  assign m_valid    = (occ != 2'd0);
  assign m_data     = head[WIDTH-1:0];
  assign m_last     = m_valid & head[WIDTH];
  assign busy       = (state_q != IDLE);
  assign beat_count = beat_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN:   if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)               state_d = RUN;
        else if (pending == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_idx_d   = inflight_q ? wrap_inc(cap_idx_q, LAST_IDX) : cap_idx_q;
    burst_idx_d = pop ? wrap_inc(burst_idx_q, LAST_IDX) : burst_idx_q;
    beat_cnt_d  = beat_cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      inflight_q  <= 1'b0;
      cap_idx_q   <= 16'd0;
      burst_idx_q <= 16'd0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= fifo_rd_en;
      cap_idx_q   <= cap_idx_d;
      burst_idx_q <= burst_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO model feeding the DUT, scoreboard on the stream.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int W      = 8;
  localparam int BL     = 4;
  localparam int CW     = 6;
  localparam int FDEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] beat_count;

  logic          wr_req = 1'b0;
  logic [W-1:0]  wr_val = '0;
  logic          fifo_flush = 1'b1;

  logic [W-1:0]  fq[$];
  logic [W-1:0]  exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mpops    = 0;
  int lasts    = 0;
  int sb_sz;
  logic         stall_prev = 1'b0;
  logic [W-1:0] data_prev = '0;
  logic         last_prev = 1'b0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(W), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .beat_count (beat_count)
  );

  // FIFO with registered read data, one cycle after an accepted read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_flush) begin
      fq.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() != 0) fifo_data <= fq.pop_front();
      if (wr_req && fq.size() < FDEPTH) fq.push_back(wr_val);
      fifo_empty <= (fq.size() == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Stream monitor: n-th beat since reset carries last when n mod BL == BL-1.
  always @(negedge clk) begin
    if (reset) begin
      mpops      = 0;
      stall_prev = 1'b0;
    end else begin
      chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
      chk("beat_count", 32'(beat_count), 32'(mpops % (1 << CW)));
      if (stall_prev) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(data_prev));
        chk("hold_last", 32'(m_last), 32'(last_prev));
      end
      if (m_valid && m_ready) begin
        sb_sz = exp_q.size();
        chk("sb_nonempty", 32'(sb_sz > 0), 1);
        if (sb_sz > 0) begin
          chk("data", 32'(m_data), 32'(exp_q.pop_front()));
          chk("last", 32'(m_last), 32'((mpops % BL) == BL - 1));
        end
        if (m_last) lasts++;
        mpops++;
      end
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      last_prev  = m_last;
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)))
    else $error("FAIL sva_hold: stream changed under backpressure");

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [W-1:0] v);
    wr_req = 1'b1;
    wr_val = v;
    exp_q.push_back(v);
    tick();
    wr_req = 1'b0;
  endtask

  task automatic drain(input int budget, input string nm);
    int n;
    n = 0;
    enable  = 1'b1;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    int n, t_rd, t_v, cnt, pops, rds, lastpop, busy_last, busy_after, stale, l0;

    repeat (3) tick();
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_beat_count", 32'(beat_count), 0);
    reset = 1'b0;
    fifo_flush = 1'b0;

    // 1: eight words, first-beat latency and back-to-back streaming
    for (int i = 1; i <= 8; i++) wr(W'(i));
    enable  = 1'b1;
    m_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!fifo_rd_en && n < 20) begin @(negedge clk); n++; end
    chk("t1_rd_seen", 32'(fifo_rd_en), 1);
    t_rd = cyc;
    while (!m_valid && n < 40) begin @(negedge clk); n++; end
    t_v = cyc;
    chk("t1_first_latency", 32'(t_v - t_rd), 2);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) cnt++;
      @(negedge clk);
    end
    chk("t1_back_to_back", cnt, 8);
    chk("t1_beat_count", 32'(beat_count), 8);
    chk("t1_valid_after", 32'(m_valid), 0);
    tick();

    // 2: ten more words; burst position continues from 8 (a multiple of BL)
    l0 = lasts;
    for (int i = 0; i < 10; i++) wr(W'(8'h20 + i));
    drain(100, "t2_drain");
    chk("t2_last_count", 32'(lasts - l0), 2);
    chk("t2_burst_idx", 32'(dut.burst_idx_q), 2);

    // 3: twenty words, ten cycles of backpressure
    enable  = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) wr(W'(8'h40 + i));
    enable = 1'b1;
    repeat (10) tick();
    chk("t3_occ_sat", 32'(dut.occ), 2);
    chk("t3_valid_held", 32'(m_valid), 1);
    chk("t3_no_pop", 32'(beat_count), 18);
    drain(200, "t3_drain");
    chk("t3_beat_count", 32'(beat_count), 38);

    // 4: enable dropped with one word buffered and one in flight
    enable  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) wr(W'(8'h60 + i));
    enable = 1'b1;
    n = 0;
    while (!(dut.occ == 2'd1 && dut.inflight_q) && n < 20) begin tick(); n++; end
    chk("t4_setup", 32'(dut.occ == 2'd1 && dut.inflight_q), 1);
    enable = 1'b0;
    pops = 0; rds = 0; lastpop = -10; busy_last = 0; busy_after = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fifo_rd_en) rds++;
      if (k == lastpop + 1) busy_after = busy;
      if (m_valid && m_ready) begin
        pops++;
        lastpop   = k;
        busy_last = busy;
      end
    end
    chk("t4_pops", pops, 2);
    chk("t4_no_reads", rds, 0);
    chk("t4_busy_at_last_pop", busy_last, 1);
    chk("t4_busy_fall", busy_after, 0);
    tick();
    drain(100, "t4_drain");

    // 5: reset with the skid buffer full; stale words must vanish
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(W'(8'h80 + i));
    repeat (4) tick();
    chk("t5_occ_full", 32'(dut.occ), 2);
    reset      = 1'b1;
    fifo_flush = 1'b1;
    exp_q.delete();
    tick();
    chk("t5_valid", 32'(m_valid), 0);
    chk("t5_beat_count", 32'(beat_count), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_state", 32'(dut.state_q), 32'(IDLE));
    chk("t5_data", 32'(m_data), 0);
    reset      = 1'b0;
    fifo_flush = 1'b0;
    m_ready    = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (m_valid) stale++;
    end
    chk("t5_no_stale", stale, 0);
    tick();

    // 6: random enable / ready / writes
    for (int i = 0; i < 2000; i++) begin
      enable  = ($urandom_range(0, 9) < 8);
      m_ready = ($urandom_range(0, 9) < 7);
      if (fq.size() < FDEPTH - 4 && $urandom_range(0, 1) == 1) begin
        wr_req = 1'b1;
        wr_val = W'($urandom);
        exp_q.push_back(wr_val);
      end else begin
        wr_req = 1'b0;
      end
      tick();
    end
    wr_req = 1'b0;
    drain(300, "t6_drain");
    enable = 1'b0;
    repeat (4) tick();
    chk("final_idle", 32'(busy), 0);
    chk("final_valid", 32'(m_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
